// File: rtl/time_set_editor.sv
`timescale 1ns/1ps
// Time-set editor: snapshots the running time, lets the user edit HH/MM/SS with
// buttons, commits through the load interface and drives LCD text while editing.
module time_set_editor #(
  parameter int unsigned LOAD_CYCLES  = 2,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned BLINK_HALF   = 250,
  parameter int unsigned TIMEOUT      = 30000
) (
  input  logic          clk_1kHz,
  input  logic          resetn,
  input  logic [15:0]   i_btns,
  input  logic [20:0]   i_current_time,
  output logic [20:0]   o_load_data,
  output logic          o_load_sig,
  output logic          o_editing,
  output logic [127:0]  o_line1,
  output logic [127:0]  o_line2
);

  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam int unsigned BL_W   = $clog2(BLINK_HALF + 1);
  localparam int unsigned LD_W   = $clog2(LOAD_CYCLES + 1);
  localparam int unsigned NB     = 5;

  // Button bit positions within the synced vector (i_btns[13:9])
  localparam int unsigned K_CANCEL = 0;
  localparam int unsigned K_DEC    = 1;
  localparam int unsigned K_INC    = 2;
  localparam int unsigned K_NEXT   = 3;
  localparam int unsigned K_SET    = 4;

  localparam logic [87:0]  L1_PREFIX = " SET TIME  ";
  localparam logic [127:0] SPACES    = {16{8'h20}};

  typedef enum logic [2:0] {S_IDLE, S_EDIT_H, S_EDIT_M, S_EDIT_S, S_COMMIT} state_t;

  state_t state_q, state_n;

  logic [NB-1:0] sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0]    prime_q;
  logic [NB-1:0] press;
  logic          any_press, p_cancel, p_set, p_next, p_inc, p_dec;

  logic [6:0]      hour_q, min_q, sec_q, hour_n, min_n, sec_n;
  logic [1:0]      sel_q, sel_n;
  logic [TO_W-1:0] to_q, to_n;
  logic [LD_W-1:0] ld_q, ld_n;
  logic [BL_W-1:0] bl_q, bl_n;
  logic            hide_q, hide_n;
  logic            rep_act_q, rep_act_n, rep_inc_q, rep_inc_n, rep_first_q, rep_first_n;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_n;
  logic            rep_level, do_up, do_dn, editing_n, blank_n;
  logic [15:0]     hh_c, mm_c, ss_c;
  logic [7:0]      ch_h, ch_m, ch_s;
  logic [127:0]    line1_n, line2_n;

  logic unused_btns;
  assign unused_btns = ^{i_btns[15:14], i_btns[8:0]};

  // Modular step of a field whose maximum value is modmax
  function automatic logic [6:0] step_val(input logic [6:0] v, input logic [6:0] modmax,
                                          input logic up);
    if (up) return (v >= modmax) ? 7'd0 : v + 7'd1;
    else    return (v == 7'd0 || v > modmax) ? modmax : v - 7'd1;
  endfunction

  // Two ASCII decimal digits with leading zero
  function automatic logic [15:0] two_digits(input logic [6:0] v);
    logic [6:0] t, o;
    t = v / 7'd10;
    o = v % 7'd10;
    return {8'h30 + {1'b0, t}, 8'h30 + {1'b0, o}};
  endfunction

  // Press decode: a press needs the synced level to have been seen low after reset
  assign press     = sync2_q & ~prev_q & armed_q;
  assign any_press = |press;
  assign p_cancel  = press[K_CANCEL];
  assign p_set     = press[K_SET]  & ~press[K_CANCEL];
  assign p_next    = press[K_NEXT] & ~press[K_SET] & ~press[K_CANCEL];
  assign p_inc     = press[K_INC]  & ~press[K_NEXT] & ~press[K_SET] & ~press[K_CANCEL];
  assign p_dec     = press[K_DEC]  & ~press[K_INC] & ~press[K_NEXT] & ~press[K_SET] &
                     ~press[K_CANCEL];
  assign rep_level = rep_inc_q ? sync2_q[K_INC] : sync2_q[K_DEC];

  assign o_load_data = {hour_q, min_q, sec_q};

  // State register
  always_ff @(posedge clk_1kHz or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_n;
  end

  // Next-state, edit datapath, auto-repeat, timeout, blink and display text
  always_comb begin
    state_n     = state_q;
    hour_n      = hour_q;
    min_n       = min_q;
    sec_n       = sec_q;
    sel_n       = sel_q;
    to_n        = '0;
    ld_n        = '0;
    bl_n        = '0;
    hide_n      = 1'b0;
    rep_act_n   = rep_act_q;
    rep_inc_n   = rep_inc_q;
    rep_first_n = rep_first_q;
    rep_cnt_n   = rep_cnt_q;
    do_up       = 1'b0;
    do_dn       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (p_set) begin
          hour_n  = (i_current_time[20:14] > 7'd23) ? 7'd0 : i_current_time[20:14];
          min_n   = (i_current_time[13:7]  > 7'd59) ? 7'd0 : i_current_time[13:7];
          sec_n   = (i_current_time[6:0]   > 7'd59) ? 7'd0 : i_current_time[6:0];
          state_n = S_EDIT_H;
        end
      end
      S_EDIT_H, S_EDIT_M, S_EDIT_S: begin
        to_n = to_q + TO_W'(1);
        if (p_cancel)    state_n = S_IDLE;
        else if (p_set)  state_n = S_COMMIT;
        else if (p_next) begin
          case (state_q)
            S_EDIT_H: state_n = S_EDIT_M;
            S_EDIT_M: state_n = S_EDIT_S;
            default:  state_n = S_EDIT_H;
          endcase
        end else if (p_inc || p_dec) begin
          do_up       = p_inc;
          do_dn       = p_dec;
          rep_act_n   = 1'b1;
          rep_inc_n   = p_inc;
          rep_first_n = 1'b1;
          rep_cnt_n   = RP_W'(1);
        end else if (rep_act_q) begin
          if (!rep_level) begin
            rep_act_n = 1'b0;
          end else if (rep_cnt_q == (rep_first_q ? RP_W'(REPEAT_DELAY - 1)
                                                 : RP_W'(REPEAT_RATE - 1))) begin
            do_up       = rep_inc_q;
            do_dn       = ~rep_inc_q;
            rep_first_n = 1'b0;
            rep_cnt_n   = RP_W'(1);
          end else begin
            rep_cnt_n = rep_cnt_q + RP_W'(1);
          end
        end
        if (any_press || do_up || do_dn) begin
          to_n = '0;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          state_n = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (ld_q == LD_W'(LOAD_CYCLES - 1)) state_n = S_IDLE;
        else                                ld_n    = ld_q + LD_W'(1);
      end
      default: state_n = S_IDLE;
    endcase

    // Apply a manual or repeat step to the selected field
    if (do_up || do_dn) begin
      case (state_q)
        S_EDIT_H: hour_n = step_val(hour_q, 7'd23, do_up);
        S_EDIT_M: min_n  = step_val(min_q,  7'd59, do_up);
        default:  sec_n  = step_val(sec_q,  7'd59, do_up);
      endcase
    end

    if (state_n != state_q) rep_act_n = 1'b0;

    case (state_n)
      S_EDIT_H: sel_n = 2'd0;
      S_EDIT_M: sel_n = 2'd1;
      S_EDIT_S: sel_n = 2'd2;
      default:  sel_n = sel_q;
    endcase

    // Blink phase runs only while editing and restarts on every press
    if (!any_press && (state_n == S_EDIT_H || state_n == S_EDIT_M || state_n == S_EDIT_S)) begin
      if (bl_q == BL_W'(BLINK_HALF - 1)) begin
        hide_n = ~hide_q;
      end else begin
        hide_n = hide_q;
        bl_n   = bl_q + BL_W'(1);
      end
    end

    editing_n = (state_n != S_IDLE);
    blank_n   = hide_n && (state_n != S_COMMIT);
    ch_h      = (sel_n == 2'd0) ? "H" : "-";
    ch_m      = (sel_n == 2'd1) ? "M" : "-";
    ch_s      = (sel_n == 2'd2) ? "S" : "-";
    hh_c      = (blank_n && sel_n == 2'd0) ? 16'h2020 : two_digits(hour_n);
    mm_c      = (blank_n && sel_n == 2'd1) ? 16'h2020 : two_digits(min_n);
    ss_c      = (blank_n && sel_n == 2'd2) ? 16'h2020 : two_digits(sec_n);
    line1_n   = editing_n ? {L1_PREFIX, ch_h, 8'h20, ch_m, 8'h20, ch_s} : SPACES;
    line2_n   = editing_n ? {32'h20202020, hh_c, 8'h3A, mm_c, 8'h3A, ss_c, 32'h20202020}
                          : SPACES;
  end

  // Button synchronisers, edge detectors and post-reset arming
  always_ff @(posedge clk_1kHz or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      prime_q <= '0;
    end else begin
      sync1_q <= i_btns[13:9];
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (prime_q != 2'd2) prime_q <= prime_q + 2'd1;
      armed_q <= armed_q | (~sync2_q & {NB{prime_q == 2'd2}});
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_1kHz or negedge resetn) begin
    if (!resetn) begin
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      sel_q       <= '0;
      to_q        <= '0;
      ld_q        <= '0;
      bl_q        <= '0;
      hide_q      <= 1'b0;
      rep_act_q   <= 1'b0;
      rep_inc_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
      o_load_sig  <= 1'b0;
      o_editing   <= 1'b0;
      o_line1     <= SPACES;
      o_line2     <= SPACES;
    end else begin
      hour_q      <= hour_n;
      min_q       <= min_n;
      sec_q       <= sec_n;
      sel_q       <= sel_n;
      to_q        <= to_n;
      ld_q        <= ld_n;
      bl_q        <= bl_n;
      hide_q      <= hide_n;
      rep_act_q   <= rep_act_n;
      rep_inc_q   <= rep_inc_n;
      rep_first_q <= rep_first_n;
      rep_cnt_q   <= rep_cnt_n;
      o_load_sig  <= (state_n == S_COMMIT);
      o_editing   <= editing_n;
      o_line1     <= line1_n;
      o_line2     <= line2_n;
    end
  end

endmodule

// File: tb/tb_time_set_editor.sv
`timescale 1ns/1ps
// Bench for time_set_editor: load strobes go through a scoreboard queue,
// display/state checks are directed with hand-computed values.
module tb_time_set_editor;

  localparam int unsigned LOAD_CYCLES = 2;

  localparam logic [15:0] B_SET = 16'h2000;
  localparam logic [15:0] B_NXT = 16'h1000;
  localparam logic [15:0] B_INC = 16'h0800;
  localparam logic [15:0] B_DEC = 16'h0400;
  localparam logic [15:0] B_CAN = 16'h0200;

  localparam logic [127:0] SP   = "                ";
  localparam logic [127:0] L1_H = " SET TIME  H - -";
  localparam logic [127:0] L1_M = " SET TIME  - M -";
  localparam logic [127:0] L1_S = " SET TIME  - - S";

  logic         clk_1kHz = 1'b0;
  logic         resetn;
  logic [15:0]  i_btns;
  logic [20:0]  i_current_time;
  logic [20:0]  o_load_data;
  logic         o_load_sig;
  logic         o_editing;
  logic [127:0] o_line1;
  logic [127:0] o_line2;

  int n_cmp = 0;
  int n_bad = 0;
  int n_loads = 0;
  logic [20:0] exp_q[$];

  time_set_editor dut (
    .clk_1kHz       (clk_1kHz),
    .resetn         (resetn),
    .i_btns         (i_btns),
    .i_current_time (i_current_time),
    .o_load_data    (o_load_data),
    .o_load_sig     (o_load_sig),
    .o_editing      (o_editing),
    .o_line1        (o_line1),
    .o_line2        (o_line2)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  function automatic logic [20:0] hms(input int h, input int m, input int s);
    return {7'(h), 7'(m), 7'(s)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_1kHz);
  endtask

  task automatic press(input logic [15:0] m);
    @(negedge clk_1kHz);
    i_btns = m;
    tick(4);
    i_btns = 16'h0;
    tick(4);
  endtask

  // Load monitor: every strobe pops one expectation and checks data and width
  logic in_strobe = 1'b0;
  int   width = 0;
  always @(negedge clk_1kHz) begin
    if (!resetn) begin
      if (in_strobe && exp_q.size() > 0) void'(exp_q.pop_front());
      in_strobe = 1'b0;
    end else if (o_load_sig) begin
      if (!in_strobe) begin
        in_strobe = 1'b1;
        width = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_load: got strobe with data %h expected no strobe", o_load_data);
        end
      end
      width++;
      if (exp_q.size() > 0) check("load_data", 128'(o_load_data), 128'(exp_q[0]));
    end else if (in_strobe) begin
      in_strobe = 1'b0;
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        check("load_width", 128'(width), 128'(LOAD_CYCLES));
        n_loads++;
      end
    end
  end

  initial begin
    bit seen;
    resetn = 1'b0;
    i_btns = 16'h0;
    i_current_time = '0;
    tick(3);
    resetn = 1'b1;
    tick(2);
    check("rst_load_sig", 128'(o_load_sig), 128'(0));
    check("rst_editing",  128'(o_editing), 128'(0));
    check("rst_line1",    o_line1, SP);
    check("rst_line2",    o_line2, SP);
    check("rst_data",     128'(o_load_data), 128'(0));

    // T1: edit and commit
    i_current_time = hms(12, 34, 56);
    press(B_SET);
    check("t1_editing", 128'(o_editing), 128'(1));
    check("t1_line1",   o_line1, L1_H);
    check("t1_line2",   o_line2, "    12:34:56    ");
    check("t1_snap",    128'(o_load_data), 128'(hms(12, 34, 56)));
    for (int i = 0; i < 3; i++) press(B_INC);
    check("t1_inc3",    128'(o_load_data), 128'(hms(15, 34, 56)));
    check("t1_line2b",  o_line2, "    15:34:56    ");
    exp_q.push_back(hms(15, 34, 56));
    press(B_SET);
    check("t1_idle",    128'(o_editing), 128'(0));
    check("t1_line1_sp", o_line1, SP);
    check("t1_hold",    128'(o_load_data), 128'(hms(15, 34, 56)));

    // T2: wrap boundaries and field cycling
    i_current_time = hms(23, 0, 59);
    press(B_SET);
    check("t2_snap", 128'(o_load_data), 128'(hms(23, 0, 59)));
    press(B_INC);
    check("t2_h_wrap", 128'(o_load_data), 128'(hms(0, 0, 59)));
    press(B_NXT);
    check("t2_line1_m", o_line1, L1_M);
    press(B_DEC);
    check("t2_m_wrap", 128'(o_load_data), 128'(hms(0, 59, 59)));
    press(B_NXT);
    check("t2_line1_s", o_line1, L1_S);
    press(B_INC);
    check("t2_s_wrap", 128'(o_load_data), 128'(hms(0, 59, 0)));
    press(B_NXT);
    check("t2_line1_h", o_line1, L1_H);
    press(B_CAN);
    check("t2_cancel", 128'(o_editing), 128'(0));
    i_current_time = hms(30, 61, 45);
    press(B_SET);
    check("t2_clamp", 128'(o_load_data), 128'(hms(0, 0, 45)));
    press(B_CAN);

    // T3: cancel drops the edit without loading
    i_current_time = hms(8, 9, 10);
    press(B_SET);
    press(B_INC);
    check("t3_inc", 128'(o_load_data), 128'(hms(9, 9, 10)));
    press(B_CAN);
    check("t3_editing", 128'(o_editing), 128'(0));
    check("t3_line1", o_line1, SP);
    check("t3_line2", o_line2, SP);

    // T4: auto-repeat over a 1000-cycle hold, then blink on the hour field
    i_current_time = hms(0, 0, 0);
    press(B_SET);
    press(B_NXT);
    press(B_NXT);
    check("t4_line1_s", o_line1, L1_S);
    @(negedge clk_1kHz);
    i_btns = B_INC;
    repeat (1000) @(posedge clk_1kHz);
    @(negedge clk_1kHz);
    i_btns = 16'h0;
    tick(6);
    check("t4_repeat", 128'(o_load_data), 128'(hms(0, 0, 7)));
    press(B_NXT);
    check("t4_show", o_line2, "    00:00:07    ");
    tick(300);
    check("t4_hide", o_line2, "      :00:07    ");
    check("t4_hide_l1", o_line1, L1_H);
    press(B_CAN);

    // T5: edit timeout and same-cycle SET+CANCEL
    i_current_time = hms(1, 2, 3);
    press(B_SET);
    tick(29890);
    check("t5_before_to", 128'(o_editing), 128'(1));
    tick(200);
    check("t5_timeout", 128'(o_editing), 128'(0));
    check("t5_line1", o_line1, SP);
    press(B_SET | B_CAN);
    check("t5_idle_tie", 128'(o_editing), 128'(0));
    press(B_SET);
    check("t5_enter", 128'(o_editing), 128'(1));
    press(B_SET | B_CAN);
    check("t5_edit_tie", 128'(o_editing), 128'(0));

    // T6: reset during commit, then a button held across reset release
    i_current_time = hms(10, 20, 30);
    press(B_SET);
    exp_q.push_back(hms(10, 20, 30));
    @(negedge clk_1kHz);
    i_btns = B_SET;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_1kHz);
      if (o_load_sig) seen = 1'b1;
    end
    check("t6_strobe_seen", 128'(seen), 128'(1));
    @(posedge clk_1kHz);
    #2 resetn = 1'b0;
    #1;
    check("t6_load_sig", 128'(o_load_sig), 128'(0));
    check("t6_editing",  128'(o_editing), 128'(0));
    check("t6_data",     128'(o_load_data), 128'(0));
    check("t6_line1",    o_line1, SP);
    tick(2);
    resetn = 1'b1;
    tick(20);
    check("t6_held_no_press", 128'(o_editing), 128'(0));
    i_btns = 16'h0;
    tick(4);
    press(B_SET);
    check("t6_rearm", 128'(o_editing), 128'(1));
    check("t6_snap",  128'(o_load_data), 128'(hms(10, 20, 30)));
    press(B_CAN);

    tick(20);
    check("pending_loads", 128'(exp_q.size()), 128'(0));
    check("load_count",    128'(n_loads), 128'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
